// File: rtl/fibonacci3_vote.sv
// Registered two-of-three vote over Fibonacci membership of three 4-bit operands.
// Each operand arrives as four scalar bits, MSB first; f carries one cycle of latency.
module fibonacci3_vote (
    input  logic clk,
    input  logic rst,
    input  logic a1,
    input  logic b1,
    input  logic c1,
    input  logic d1,
    input  logic a2,
    input  logic b2,
    input  logic c2,
    input  logic d2,
    input  logic a3,
    input  logic b3,
    input  logic c3,
    input  logic d3,
    output logic f
);

    logic [3:0] n1, n2, n3;
    logic       is_fib1, is_fib2, is_fib3;
    logic       vote;

    assign n1 = {a1, b1, c1, d1};
    assign n2 = {a2, b2, c2, d2};
    assign n3 = {a3, b3, c3, d3};

    // Membership in {0,1,2,3,5,8,13}: bit i of the mask is set when i is a Fibonacci value.
    localparam logic [15:0] FIB_MASK = 16'b0010_0001_0010_1111;

    assign is_fib1 = FIB_MASK[n1];
    assign is_fib2 = FIB_MASK[n2];
    assign is_fib3 = FIB_MASK[n3];

    assign vote = (is_fib1 & is_fib2) | (is_fib1 & is_fib3) | (is_fib2 & is_fib3);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            f <= 1'b0;
        else
            f <= vote;
    end

endmodule

// File: tb/tb_fibonacci3_vote.sv
// Directed table-driven bench for fibonacci3_vote: reset, mixed vectors, N1 sweep,
// latency, mid-cycle reset and the single-Fibonacci boundary.
module tb_fibonacci3_vote;

    logic clk = 1'b0;
    logic rst;
    logic a1, b1, c1, d1;
    logic a2, b2, c2, d2;
    logic a3, b3, c3, d3;
    logic f;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] n1;
        logic [3:0] n2;
        logic [3:0] n3;
        logic       exp_f;
    } vec_t;

    vec_t vecs[$];

    fibonacci3_vote dut (
        .clk(clk), .rst(rst),
        .a1(a1), .b1(b1), .c1(c1), .d1(d1),
        .a2(a2), .b2(b2), .c2(c2), .d2(d2),
        .a3(a3), .b3(b3), .c3(c3), .d3(d3),
        .f(f)
    );

    always #5 clk = ~clk;

    task automatic set_ops(input logic [3:0] n1, input logic [3:0] n2, input logic [3:0] n3);
        {a1, b1, c1, d1} = n1;
        {a2, b2, c2, d2} = n2;
        {a3, b3, c3, d3} = n3;
    endtask

    task automatic check(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: f=%b expected=%b", name, actual, expected);
        end
    endtask

    // Apply inputs mid-low phase, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [3:0] n1, input logic [3:0] n2, input logic [3:0] n3);
        set_ops(n1, n2, n3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Mixed vectors.
        vecs.push_back('{4'd11, 4'd0,  4'd1,  1'b1});
        vecs.push_back('{4'd10, 4'd2,  4'd0,  1'b1});
        vecs.push_back('{4'd6,  4'd6,  4'd6,  1'b0});
        vecs.push_back('{4'd15, 4'd5,  4'd1,  1'b1});
        vecs.push_back('{4'd11, 4'd14, 4'd8,  1'b0});
        vecs.push_back('{4'd15, 4'd15, 4'd15, 1'b0});
        vecs.push_back('{4'd5,  4'd5,  4'd5,  1'b1});
        vecs.push_back('{4'd0,  4'd0,  4'd0,  1'b1});
        // N1 sweep with N2=3 (Fibonacci) and N3=4 (not): f follows N1's membership.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] n;
            n = 4'(i);
            vecs.push_back('{n, 4'd3, 4'd4,
                             (i == 0 || i == 1 || i == 2 || i == 3 ||
                              i == 5 || i == 8 || i == 13) ? 1'b1 : 1'b0});
        end

        // Reset: asynchronous clear, no clock edge required.
        set_ops(4'd0, 4'd0, 4'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_async", f, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", f, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_no_edge", f, 1'b0);
        step(4'd0, 4'd0, 4'd0);
        check("first_edge_000", f, 1'b1);

        // Table.
        foreach (vecs[i]) begin
            @(negedge clk);
            step(vecs[i].n1, vecs[i].n2, vecs[i].n3);
            check($sformatf("vec%0d_%0d_%0d_%0d", i, vecs[i].n1, vecs[i].n2, vecs[i].n3),
                  f, vecs[i].exp_f);
        end

        // Latency: change between edges, f must hold until the next edge.
        @(negedge clk);
        step(4'd4, 4'd4, 4'd4);
        check("lat_444", f, 1'b0);
        #2;
        set_ops(4'd13, 4'd8, 4'd5);
        #1;
        check("lat_hold_after_change", f, 1'b0);
        @(negedge clk);
        check("lat_hold_negedge", f, 1'b0);
        @(posedge clk);
        #1;
        check("lat_next_edge", f, 1'b1);

        // Mid-operation reset pulse between edges.
        @(negedge clk);
        step(4'd1, 4'd2, 4'd3);
        check("mid_pre", f, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_async", f, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_released", f, 1'b0);
        @(posedge clk);
        #1;
        check("mid_rst_recover", f, 1'b1);

        // Single-Fibonacci boundary.
        @(negedge clk);
        step(4'd5, 4'd9, 4'd12);
        check("single_fib_5_9_12", f, 1'b0);
        @(negedge clk);
        step(4'd5, 4'd9, 4'd13);
        check("two_fib_5_9_13", f, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
